// File: rtl/dmi_dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmi_dm_responder
// Purpose  : Core-clock-domain RISC-V Debug Module responder. Accepts DMI
//            requests {addr, data, op}, decodes data0 / dmcontrol / dmstatus /
//            abstractcs / command, runs abstract GPR access commands against
//            the RV32I register file and returns {data, resp} responses.
// Ports    : cclk, dev_rst             - core clock, async active-high reset
//            creq_vld/creq_data/creq_rdy  - DMI request channel
//            cresp_vld/cresp_data/cresp_rdy - DMI response channel
//            hart_halted               - hart halted status
//            haltreq/resumereq/ndmreset/dmactive - debug control outputs
//            reg_req/reg_wr/reg_addr/reg_wdata/reg_rdata/reg_ack - GPR port
// Revision : 1.0 - initial release
// ============================================================================
module dmi_dm_responder #(
  parameter int ABITS    = 7,
  parameter int TX_WIDTH = ABITS + 32 + 2,
  parameter int RX_WIDTH = 32 + 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                cclk,
  input  logic                dev_rst,
  input  logic                creq_vld,
  input  logic [TX_WIDTH-1:0] creq_data,
  output logic                creq_rdy,
  output logic                cresp_vld,
  output logic [RX_WIDTH-1:0] cresp_data,
  input  logic                cresp_rdy,
  input  logic                hart_halted,
  output logic                haltreq,
  output logic                resumereq,
  output logic                ndmreset,
  output logic                dmactive,
  output logic                reg_req,
  output logic                reg_wr,
  output logic [4:0]          reg_addr,
  output logic [31:0]         reg_wdata,
  input  logic [31:0]         reg_rdata,
  input  logic                reg_ack
);

  localparam logic [ABITS-1:0] ADDR_DATA0      = ABITS'(7'h04);
  localparam logic [ABITS-1:0] ADDR_DMCONTROL  = ABITS'(7'h10);
  localparam logic [ABITS-1:0] ADDR_DMSTATUS   = ABITS'(7'h11);
  localparam logic [ABITS-1:0] ADDR_ABSTRACTCS = ABITS'(7'h16);
  localparam logic [ABITS-1:0] ADDR_COMMAND    = ABITS'(7'h17);

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  // Timeout counter holds 0..TIMEOUT-1; the last value marks expiry.
  localparam int             TCW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TCW-1:0] TCNT_LAST = TCW'(TIMEOUT - 1);

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_RESP = 1'b1;

  localparam logic [1:0] A_IDLE = 2'd0;
  localparam logic [1:0] A_REQ  = 2'd1;
  localparam logic [1:0] A_WAIT = 2'd2;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  logic [0:0]          rstate_q, rstate_d;
  logic [1:0]          astate_q, astate_d;
  logic [RX_WIDTH-1:0] resp_q, resp_d;
  logic [31:0]         data0_q, data0_d;
  logic                haltreq_q, haltreq_d;
  logic                resumereq_q, resumereq_d;
  logic                ndmreset_q, ndmreset_d;
  logic                dmactive_q, dmactive_d;
  logic                resume_pend_q, resume_pend_d;
  logic                resumeack_q, resumeack_d;
  logic [2:0]          cmderr_q, cmderr_d;
  logic [TCW-1:0]      tcnt_q, tcnt_d;
  logic                reg_wr_q, reg_wr_d;
  logic [4:0]          reg_addr_q, reg_addr_d;
  logic [31:0]         reg_wdata_q, reg_wdata_d;

  // --------------------------------------------------------------------------
  // Request field extraction and decode
  // --------------------------------------------------------------------------
  logic [ABITS-1:0] w_addr;
  logic [31:0]      w_wdata;
  logic [1:0]       w_op;
  logic             w_acc, w_rd, w_wr;
  logic             w_busy, w_ack_done, w_tmo;
  logic [31:0]      w_data0_cur;
  logic             w_busy_err;
  logic             w_cmd_wr, w_cmd_bad, w_cmd_start;
  logic             w_dmc_wr;
  logic [31:0]      w_rd_val;

  assign w_addr  = creq_data[TX_WIDTH-1 -: ABITS];
  assign w_wdata = creq_data[33:2];
  assign w_op    = creq_data[1:0];

  assign w_acc = creq_vld && creq_rdy;
  assign w_rd  = w_acc && (w_op == OP_READ);
  assign w_wr  = w_acc && (w_op == OP_WRITE);

  assign w_busy     = (astate_q != A_IDLE);
  assign w_ack_done = (astate_q == A_WAIT) && reg_ack;
  assign w_tmo      = (astate_q == A_WAIT) && !reg_ack && (tcnt_q == TCNT_LAST);

  // A completing read-back lands in data0 before any same-cycle DMI access
  // observes it.
  assign w_data0_cur = (w_ack_done && !reg_wr_q) ? reg_rdata : data0_q;

  // data0/command touched while a command is in flight. A command write with
  // dmactive=0 is ignored outright and so raises nothing.
  assign w_busy_err = w_busy &&
                      (((w_addr == ADDR_DATA0) && (w_rd || w_wr)) ||
                       ((w_addr == ADDR_COMMAND) && (w_rd || (w_wr && dmactive_q))));

  assign w_cmd_wr  = w_wr && (w_addr == ADDR_COMMAND) && dmactive_q &&
                     !w_busy && (cmderr_q == 3'd0);
  assign w_cmd_bad = (w_wdata[31:24] != 8'd0) || (w_wdata[22:20] != 3'd2) ||
                     (w_wdata[17] && ((w_wdata[15:0] < 16'h1000) ||
                                      (w_wdata[15:0] > 16'h101F)));
  assign w_cmd_start = w_cmd_wr && !w_cmd_bad && hart_halted && w_wdata[17];

  assign w_dmc_wr = w_wr && (w_addr == ADDR_DMCONTROL);

  // Read data mux
  always_comb begin
    w_rd_val = 32'd0;
    case (w_addr)
      ADDR_DATA0:      w_rd_val = w_data0_cur;
      ADDR_DMCONTROL:  w_rd_val = {haltreq_q, 29'd0, ndmreset_q, dmactive_q};
      ADDR_DMSTATUS:   w_rd_val = {14'd0, resumeack_q, resumeack_q, 4'd0,
                                   ~hart_halted, ~hart_halted,
                                   hart_halted, hart_halted,
                                   1'b1, 3'd0, 4'd2};
      ADDR_ABSTRACTCS: w_rd_val = {19'd0, w_busy, 1'b0, cmderr_q, 4'd0, 4'd1};
      default:         w_rd_val = 32'd0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge cclk or posedge dev_rst) begin
    if (dev_rst) rstate_q <= R_IDLE;
    else         rstate_q <= rstate_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (creq_vld) rstate_d = R_RESP;
      R_RESP:  if (cresp_rdy) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  // Ready is masked by reset so every output reads 0 while reset is held.
  always_comb begin
    creq_rdy  = (rstate_q == R_IDLE) && !dev_rst;
    cresp_vld = (rstate_q == R_RESP);
  end

  // --------------------------------------------------------------------------
  // Abstract command FSM: state register / next state / outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge cclk or posedge dev_rst) begin
    if (dev_rst) astate_q <= A_IDLE;
    else         astate_q <= astate_d;
  end

  always_comb begin
    astate_d = astate_q;
    case (astate_q)
      A_IDLE:  if (w_cmd_start) astate_d = A_REQ;
      A_REQ:   astate_d = A_WAIT;
      A_WAIT:  if (reg_ack || w_tmo) astate_d = A_IDLE;
      default: astate_d = A_IDLE;
    endcase
  end

  always_comb begin
    reg_req = (astate_q == A_REQ) || (astate_q == A_WAIT);
  end

  // --------------------------------------------------------------------------
  // Datapath next state
  // --------------------------------------------------------------------------
  always_comb begin
    resp_d        = resp_q;
    data0_d       = w_data0_cur;
    haltreq_d     = haltreq_q;
    resumereq_d   = 1'b0;
    ndmreset_d    = ndmreset_q;
    dmactive_d    = dmactive_q;
    resume_pend_d = resume_pend_q;
    resumeack_d   = resumeack_q;
    cmderr_d      = cmderr_q;
    tcnt_d        = (astate_q == A_WAIT) ? tcnt_q + TCW'(1) : '0;
    reg_wr_d      = reg_wr_q;
    reg_addr_d    = reg_addr_q;
    reg_wdata_d   = reg_wdata_q;

    if (w_acc) begin
      case (w_op)
        OP_READ: resp_d = RX_WIDTH'({w_rd_val, 2'b00});
        OP_RSVD: resp_d = RX_WIDTH'({32'd0, 2'b10});
        default: resp_d = '0;
      endcase
    end

    if (w_wr && (w_addr == ADDR_DATA0) && !w_busy) data0_d = w_wdata;

    // Ack arrives only once the hart has left the halted state.
    if (resume_pend_q && !hart_halted) begin
      resumeack_d   = 1'b1;
      resume_pend_d = 1'b0;
    end

    if (w_wr && (w_addr == ADDR_ABSTRACTCS)) cmderr_d = cmderr_q & ~w_wdata[10:8];

    if (w_dmc_wr) begin
      haltreq_d   = w_wdata[31];
      ndmreset_d  = w_wdata[1];
      dmactive_d  = w_wdata[0];
      resumereq_d = w_wdata[30];
      if (w_wdata[30]) begin
        resumeack_d   = 1'b0;
        resume_pend_d = 1'b1;
      end
      if (!w_wdata[0]) begin
        data0_d    = 32'd0;
        haltreq_d  = 1'b0;
        ndmreset_d = 1'b0;
        cmderr_d   = 3'd0;
      end
    end

    // New errors are applied last so they override a same-cycle W1C clear.
    if (w_busy_err && (cmderr_q == 3'd0)) cmderr_d = 3'd1;
    if (w_cmd_wr) begin
      if (w_cmd_bad)         cmderr_d = 3'd2;
      else if (!hart_halted) cmderr_d = 3'd4;
    end
    if (w_tmo) cmderr_d = 3'd3;

    if (w_cmd_start) begin
      reg_wr_d    = w_wdata[16];
      reg_addr_d  = w_wdata[4:0];
      reg_wdata_d = data0_q;
    end
  end

  always_ff @(posedge cclk or posedge dev_rst) begin
    if (dev_rst) begin
      resp_q        <= '0;
      data0_q       <= 32'd0;
      haltreq_q     <= 1'b0;
      resumereq_q   <= 1'b0;
      ndmreset_q    <= 1'b0;
      dmactive_q    <= 1'b0;
      resume_pend_q <= 1'b0;
      resumeack_q   <= 1'b0;
      cmderr_q      <= 3'd0;
      tcnt_q        <= '0;
      reg_wr_q      <= 1'b0;
      reg_addr_q    <= 5'd0;
      reg_wdata_q   <= 32'd0;
    end else begin
      resp_q        <= resp_d;
      data0_q       <= data0_d;
      haltreq_q     <= haltreq_d;
      resumereq_q   <= resumereq_d;
      ndmreset_q    <= ndmreset_d;
      dmactive_q    <= dmactive_d;
      resume_pend_q <= resume_pend_d;
      resumeack_q   <= resumeack_d;
      cmderr_q      <= cmderr_d;
      tcnt_q        <= tcnt_d;
      reg_wr_q      <= reg_wr_d;
      reg_addr_q    <= reg_addr_d;
      reg_wdata_q   <= reg_wdata_d;
    end
  end

  assign cresp_data = resp_q;
  assign haltreq    = haltreq_q;
  assign resumereq  = resumereq_q;
  assign ndmreset   = ndmreset_q;
  assign dmactive   = dmactive_q;
  assign reg_wr     = reg_wr_q;
  assign reg_addr   = reg_addr_q;
  assign reg_wdata  = reg_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmi_dm_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmi_dm_responder
// Purpose  : Self-checking bench for dmi_dm_responder: directed scenarios
//            followed by randomized DMI traffic against a register-level
//            reference model of the debug module.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmi_dm_responder;

  logic        cclk = 1'b0;
  logic        dev_rst = 1'b1;
  logic        creq_vld = 1'b0;
  logic [40:0] creq_data = '0;
  logic        creq_rdy;
  logic        cresp_vld;
  logic [33:0] cresp_data;
  logic        cresp_rdy = 1'b1;
  logic        hart_halted = 1'b0;
  logic        haltreq, resumereq, ndmreset, dmactive;
  logic        reg_req, reg_wr;
  logic [4:0]  reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata = '0;
  logic        reg_ack = 1'b0;

  dmi_dm_responder dut (
    .cclk(cclk), .dev_rst(dev_rst),
    .creq_vld(creq_vld), .creq_data(creq_data), .creq_rdy(creq_rdy),
    .cresp_vld(cresp_vld), .cresp_data(cresp_data), .cresp_rdy(cresp_rdy),
    .hart_halted(hart_halted), .haltreq(haltreq), .resumereq(resumereq),
    .ndmreset(ndmreset), .dmactive(dmactive),
    .reg_req(reg_req), .reg_wr(reg_wr), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack)
  );

  always #5 cclk = ~cclk;

  int n_cmp = 0;
  int n_bad = 0;
  logic last_resume;

  // Reference model state
  logic [31:0] m_data0;
  logic        m_haltreq, m_ndm, m_act, m_pend, m_ack;
  logic [2:0]  m_cmderr;
  logic [31:0] m_gpr   [32];
  logic [31:0] dev_gpr [32];

  // Scratch
  logic [31:0] rd, exp_rd, wd, saved32;
  logic [33:0] saved;
  logic [1:0]  rs, exp_rs, op;
  logic [6:0]  a;
  logic        start, s_wr, done;
  logic [4:0]  s_idx;
  int          n;

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] all_outs();
    return 96'({creq_rdy, cresp_vld, cresp_data, haltreq, resumereq, ndmreset,
                dmactive, reg_req, reg_wr, reg_addr, reg_wdata});
  endfunction

  // One complete DMI transaction with cresp_rdy held high.
  task automatic dmi(input logic [1:0] o, input logic [6:0] ad, input logic [31:0] d,
                     output logic [31:0] r, output logic [1:0] s);
    int k;
    k = 0;
    creq_vld  = 1'b1;
    creq_data = {ad, d, o};
    while (!creq_rdy && k < 50) begin tick(); k++; end
    if (k >= 50) check("req_rdy_timeout", 96'(creq_rdy), 96'd1);
    tick();
    creq_vld = 1'b0;
    check("resp_latency", 96'(cresp_vld), 96'd1);
    r = cresp_data[33:2];
    s = cresp_data[1:0];
    last_resume = resumereq;
    tick();
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] v;
    v = 32'h0000_0082;
    v = v | (hart_halted ? 32'h0000_0300 : 32'h0000_0C00);
    if (m_ack) v = v | 32'h0003_0000;
    return v;
  endfunction

  task automatic m_settle();
    if (m_pend && !hart_halted) begin m_ack = 1'b1; m_pend = 1'b0; end
  endtask

  // Plays the GPR file for one abstract command issued by the DUT.
  task automatic serve(input logic wr_exp, input logic [4:0] idx, input int dly);
    int k;
    k = 0;
    while (!reg_req && k < 20) begin tick(); k++; end
    check("srv_req", 96'(reg_req), 96'd1);
    check("srv_wr", 96'(reg_wr), 96'(wr_exp));
    check("srv_addr", 96'(reg_addr), 96'(idx));
    check("srv_wdata", 96'(reg_wdata), 96'(m_data0));
    repeat (dly + 1) tick();
    if (reg_wr) dev_gpr[reg_addr] = reg_wdata;
    reg_rdata = dev_gpr[reg_addr];
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    if (wr_exp) m_gpr[idx] = m_data0;
    else        m_data0 = m_gpr[idx];
  endtask

  initial begin
    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_outs", all_outs(), 96'd0);
    dev_rst = 1'b0;
    #1;
    check("rst_rdy", 96'(creq_rdy), 96'd1);

    // ---------------- data0 write/read ----------------
    dmi(2'd2, 7'h04, 32'hDEADBEEF, rd, rs);
    check("d0_wr_resp", 96'(rs), 96'd0);
    dmi(2'd1, 7'h04, 32'h0, rd, rs);
    check("d0_rd", 96'({rd, rs}), 96'({32'hDEADBEEF, 2'b00}));

    // ---------------- response backpressure ----------------
    cresp_rdy = 1'b0;
    creq_vld  = 1'b1;
    creq_data = {7'h04, 32'h0, 2'd1};
    tick();
    creq_vld = 1'b0;
    check("bp_vld0", 96'(cresp_vld), 96'd1);
    saved = cresp_data;
    check("bp_data0", 96'(saved), 96'({32'hDEADBEEF, 2'b00}));
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_vld", 96'(cresp_vld), 96'd1);
      check("bp_data", 96'(cresp_data), 96'(saved));
      check("bp_rdy", 96'(creq_rdy), 96'd0);
    end
    cresp_rdy = 1'b1;
    tick();
    check("bp_vld_after", 96'(cresp_vld), 96'd0);
    check("bp_rdy_after", 96'(creq_rdy), 96'd1);

    // ---------------- dmcontrol / dmstatus ----------------
    hart_halted = 1'b1;
    dmi(2'd2, 7'h10, 32'h80000001, rd, rs);
    check("haltreq", 96'(haltreq), 96'd1);
    check("dmactive", 96'(dmactive), 96'd1);
    dmi(2'd1, 7'h11, 32'h0, rd, rs);
    check("dmstatus", 96'(rd), 96'h382);
    dmi(2'd1, 7'h10, 32'h0, rd, rs);
    check("dmcontrol_rd", 96'(rd), 96'h80000001);

    // ---------------- abstract write x5 ----------------
    dmi(2'd2, 7'h04, 32'h12345678, rd, rs);
    dmi(2'd2, 7'h17, 32'h00231005, rd, rs);
    check("aw_req", 96'(reg_req), 96'd1);
    check("aw_wr", 96'(reg_wr), 96'd1);
    check("aw_addr", 96'(reg_addr), 96'd5);
    check("aw_wdata", 96'(reg_wdata), 96'h12345678);
    dmi(2'd1, 7'h16, 32'h0, rd, rs);
    check("aw_busy", 96'(rd), 96'h1001);
    dmi(2'd2, 7'h04, 32'hFFFFFFFF, rd, rs);      // discarded, flags cmderr=1
    check("busy_acc_resp", 96'(rs), 96'd0);
    check("aw_req_held", 96'(reg_req), 96'd1);
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    check("aw_req_drop", 96'(reg_req), 96'd0);
    dmi(2'd1, 7'h16, 32'h0, rd, rs);
    check("aw_done_cmderr1", 96'(rd), 96'h101);
    dmi(2'd1, 7'h04, 32'h0, rd, rs);
    check("busy_wr_discard", 96'(rd), 96'h12345678);
    dmi(2'd2, 7'h16, 32'h100, rd, rs);
    dmi(2'd1, 7'h16, 32'h0, rd, rs);
    check("w1c_clear", 96'(rd), 96'h1);

    // ---------------- abstract read x3 ----------------
    dmi(2'd2, 7'h17, 32'h00221003, rd, rs);
    check("ar_wr", 96'(reg_wr), 96'd0);
    check("ar_addr", 96'(reg_addr), 96'd3);
    repeat (2) tick();
    reg_rdata = 32'hCAFEF00D;
    reg_ack   = 1'b1;
    tick();
    reg_ack = 1'b0;
    dmi(2'd1, 7'h04, 32'h0, rd, rs);
    check("ar_data0", 96'(rd), 96'hCAFEF00D);

    // ---------------- timeout ----------------
    dmi(2'd2, 7'h17, 32'h00221003, rd, rs);
    n = 0;
    while (reg_req && n < 400) begin tick(); n++; end
    check("tmo_len", 96'((n >= 254) && (n <= 256)), 96'd1);
    dmi(2'd1, 7'h16, 32'h0, rd, rs);
    check("tmo_cmderr", 96'(rd), 96'h301);
    dmi(2'd2, 7'h17, 32'h00231005, rd, rs);      // ignored while cmderr!=0
    check("cmd_ignored", 96'(reg_req), 96'd0);
    dmi(2'd2, 7'h16, 32'h700, rd, rs);
    dmi(2'd1, 7'h16, 32'h0, rd, rs);
    check("tmo_clear", 96'(rd), 96'h1);

    // ---------------- not halted / bad command ----------------
    hart_halted = 1'b0;
    tick();
    dmi(2'd2, 7'h17, 32'h00231005, rd, rs);
    check("nh_noreq", 96'(reg_req), 96'd0);
    dmi(2'd1, 7'h16, 32'h0, rd, rs);
    check("nh_cmderr4", 96'(rd), 96'h401);
    dmi(2'd2, 7'h16, 32'h700, rd, rs);
    dmi(2'd2, 7'h17, 32'h00331005, rd, rs);      // aarsize=3 checked before halt
    dmi(2'd1, 7'h16, 32'h0, rd, rs);
    check("bad_cmderr2", 96'(rd), 96'h201);
    dmi(2'd2, 7'h16, 32'h700, rd, rs);

    // ---------------- reserved op / unmapped ----------------
    dmi(2'd3, 7'h04, 32'h5555AAAA, rd, rs);
    check("op3", 96'({rd, rs}), 96'({32'd0, 2'b10}));
    dmi(2'd1, 7'h20, 32'h0, rd, rs);
    check("unmapped", 96'({rd, rs}), 96'd0);

    // ---------------- reset during A_WAIT ----------------
    hart_halted = 1'b1;
    tick();
    dmi(2'd2, 7'h17, 32'h00221003, rd, rs);
    check("pre_rst_req", 96'(reg_req), 96'd1);
    dev_rst = 1'b1;
    #1;
    check("async_rst_outs", all_outs(), 96'd0);
    tick();
    dev_rst = 1'b0;
    tick();
    dmi(2'd1, 7'h04, 32'h0, rd, rs);
    check("rst_data0", 96'(rd), 96'd0);

    // ---------------- randomized traffic vs model ----------------
    m_data0 = '0; m_haltreq = 0; m_ndm = 0; m_act = 0; m_pend = 0; m_ack = 0;
    m_cmderr = '0;
    for (int i = 0; i < 32; i++) begin
      m_gpr[i]   = $urandom;
      dev_gpr[i] = m_gpr[i];
    end
    for (int it = 0; it < 250; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        hart_halted = ($urandom_range(0, 3) != 0);
        tick(); tick();
        m_settle();
      end
      case ($urandom_range(0, 6))
        0:       a = 7'h04;
        1:       a = 7'h10;
        2:       a = 7'h11;
        3:       a = 7'h16;
        4, 5:    a = 7'h17;
        default: begin
          a = 7'($urandom_range(0, 127));
          if (a == 7'h04 || a == 7'h10 || a == 7'h11 || a == 7'h16 || a == 7'h17) a = 7'h7F;
        end
      endcase
      op = 2'($urandom_range(0, 3));
      if (op == 2'd0 && $urandom_range(0, 1) == 1) op = 2'd2;
      wd = $urandom;
      if (a == 7'h10) wd[0] = ($urandom_range(0, 7) != 0);
      if (a == 7'h17) begin
        n = $urandom_range(0, 4);
        if (n == 0)      wd = 32'h00220000 | (32'h1000 + 32'($urandom_range(0, 31)));
        else if (n == 1) wd = 32'h00230000 | (32'h1000 + 32'($urandom_range(0, 31)));
        else if (n == 2) wd = 32'h00200000 | 32'($urandom_range(0, 65535));
        else if (n == 3) wd = 32'h00231020 + 32'($urandom_range(0, 3));
      end

      exp_rd = 32'd0; exp_rs = 2'd0; start = 1'b0; s_wr = 1'b0; s_idx = 5'd0;
      if (op == 2'd3) exp_rs = 2'd2;
      else if (op == 2'd1) begin
        case (a)
          7'h04:   exp_rd = m_data0;
          7'h10:   exp_rd = {m_haltreq, 29'd0, m_ndm, m_act};
          7'h11:   exp_rd = m_status();
          7'h16:   exp_rd = 32'h1 | (32'(m_cmderr) << 8);
          default: exp_rd = 32'd0;
        endcase
      end else if (op == 2'd2) begin
        case (a)
          7'h04: m_data0 = wd;
          7'h10: begin
            if (wd[30]) begin m_ack = 1'b0; m_pend = 1'b1; end
            if (wd[0]) begin
              m_haltreq = wd[31]; m_ndm = wd[1]; m_act = 1'b1;
            end else begin
              m_haltreq = 0; m_ndm = 0; m_act = 0; m_data0 = 0; m_cmderr = 0;
            end
          end
          7'h16: m_cmderr = m_cmderr & ~wd[10:8];
          7'h17: begin
            if (m_act && m_cmderr == 3'd0) begin
              if (wd[31:24] != 0 || wd[22:20] != 3'd2 ||
                  (wd[17] && (wd[15:0] < 16'h1000 || wd[15:0] > 16'h101F)))
                m_cmderr = 3'd2;
              else if (!hart_halted)
                m_cmderr = 3'd4;
              else if (wd[17]) begin
                start = 1'b1; s_wr = wd[16]; s_idx = 5'(wd[15:0] - 16'h1000);
              end
            end
          end
          default: ;
        endcase
      end

      dmi(op, a, wd, rd, rs);
      check("rnd_data", 96'(rd), 96'(exp_rd));
      check("rnd_resp", 96'(rs), 96'(exp_rs));
      check("rnd_resume", 96'(last_resume), 96'(op == 2'd2 && a == 7'h10 && wd[30]));
      check("rnd_ctrl", 96'({haltreq, ndmreset, dmactive}), 96'({m_haltreq, m_ndm, m_act}));
      check("rnd_reqidle", 96'(reg_req), 96'(start));
      if (start) serve(s_wr, s_idx, $urandom_range(0, 5));
      m_settle();
    end

    // Final read-back of data0 and abstractcs
    dmi(2'd1, 7'h04, 32'h0, rd, rs);
    check("end_data0", 96'(rd), 96'(m_data0));
    saved32 = 32'h1 | (32'(m_cmderr) << 8);
    dmi(2'd1, 7'h16, 32'h0, rd, rs);
    check("end_abscs", 96'(rd), 96'(saved32));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmi_dm_responder.md
Name: dmi_dm_responder

Overview:
- Core-clock-domain Debug Module responder: the far end of the DMI request/response channel that the JTAG DMI interconnect drives on its core side.
- Consumes DMI requests {addr[6:0], data[31:0], op[1:0]} and decodes a minimal RISC-V debug register set (data0, dmcontrol, dmstatus, abstractcs, command).
- Runs abstract register-access commands against the RV32I GPR file.
- Returns {data[31:0], resp[1:0]} responses.

Parameters:
- ABITS, 7, DMI address width
- TX_WIDTH, ABITS+32+2, request word width
- RX_WIDTH, 32+2, response word width
- TIMEOUT, 255, cycles to wait for reg_ack before the abstract command errors

Ports:
- cclk  in  1  core clock
- dev_rst  in  1  asynchronous active-high reset
- creq_vld  in  1  request valid
- creq_data  in  TX_WIDTH  {addr[40:34], data[33:2], op[1:0]}
- creq_rdy  out  1  request ready
- cresp_vld  out  1  response valid
- cresp_data  out  RX_WIDTH  {data[33:2], resp[1:0]}
- cresp_rdy  in  1  response ready
- hart_halted  in  1  hart halted status
- haltreq  out  1  halt request level (dmcontrol[31])
- resumereq  out  1  one-cycle resume pulse
- ndmreset  out  1  system reset request (dmcontrol[1])
- dmactive  out  1  dmcontrol[0]
- reg_req  out  1  GPR access request, held until reg_ack
- reg_wr  out  1  1 = write
- reg_addr  out  5  GPR index
- reg_wdata  out  32  write data
- reg_rdata  in  32  read data, valid with reg_ack
- reg_ack  in  1  access done

Behaviour:
- Reset: all outputs 0, all registers 0, both FSMs idle. Assertion mid-transaction aborts everything immediately.
- Request FSM states: IDLE, RESP.
  - IDLE: creq_rdy=1. On creq_vld&creq_rdy the request is decoded in that cycle; the next cycle enters RESP with cresp_vld=1, creq_rdy=0, cresp_data registered.
  - RESP: cresp_vld and cresp_data are held stable until cresp_vld&cresp_rdy. After that handshake, cresp_vld=0 and the FSM returns to IDLE, so creq_rdy=1 the following cycle.
  - Only one outstanding request at a time.
- Op codes:
  - 0 nop: data 0, resp 0.
  - 1 read, 2 write: resp 0.
  - 3 reserved: data 0, resp 2, no side effect.
  - A read or write of data0 or command while the abstract FSM is busy returns resp 0 (busy is reported only via cmderr). Sets cmderr=1 if cmderr==0; write discarded, read returns current value.
- Register map:
  - 0x04 data0: RW.
  - 0x10 dmcontrol: [31] haltreq RW, [30] resumereq W-only (pulses resumereq 1 cycle, reads 0), [1] ndmreset RW, [0] dmactive RW.
    - Writing dmactive=0 clears data0, haltreq, ndmreset, cmderr; dmactive reads 0.
  - 0x11 dmstatus: RO.
    - [3:0]=2; [7]=1 (authenticated).
    - [9:8]={2{hart_halted}}; [11:10]={2{~hart_halted}}.
    - [17:16] allresumeack/anyresumeack: set by a resumereq write once hart_halted=0, cleared on the next resumereq write.
  - 0x16 abstractcs: [28:24]=0, [12] busy RO, [10:8] cmderr W1C, [3:0]=1.
  - 0x17 command: W-only, reads 0.
  - Other addresses: read 0, write ignored, resp 0.
- Writes to command while dmactive=0 are ignored.
- Abstract FSM states: A_IDLE, A_REQ, A_WAIT.
  - A command write in A_IDLE with cmderr==0 is checked in order:
    - cmdtype[31:24]!=0, aarsize[22:20]!=2, or (transfer[17]=1 and regno[15:0] outside 0x1000..0x101F) -> cmderr=2, no access.
    - hart_halted=0 -> cmderr=4.
    - transfer=0 -> completes with no access.
    - Otherwise busy=1 and the FSM enters A_REQ.
  - A command write with cmderr!=0 is ignored.
  - A_REQ: reg_req=1, reg_wr=write[16], reg_addr=regno[4:0], reg_wdata=data0; then A_WAIT.
  - A_WAIT: reg_req stays high until reg_ack.
    - On reg_ack: reg_req=0, busy=0; if reg_wr=0, data0<=reg_rdata.
    - A timeout counter counts cycles in A_WAIT; when it reaches TIMEOUT: reg_req=0, busy=0, cmderr=3.
- Simultaneous events:
  - reg_ack and a data0 DMI access in the same cycle: the ack is completed first, then the access is flagged busy.
  - A cmderr W1C write in the same cycle as a new error: the new error wins.

Test Plan:
- Write data0=0xDEADBEEF (op 2, addr 0x04), then read it -> read response cresp_data={0xDEADBEEF,2'b00}; cresp_vld rises exactly 1 cycle after accept.
- Hold cresp_rdy=0 for 5 cycles -> cresp_vld/cresp_data stable and creq_rdy=0 throughout; after the handshake creq_rdy=1 on the next cycle.
- dmcontrol write 0x80000001, hart_halted=1 -> haltreq=1, dmactive=1, dmstatus read = 0x00000382.
- Halted; data0=0x12345678; command=0x00231005 -> reg_req=1, reg_wr=1, reg_addr=5, reg_wdata=0x12345678; busy reads 1 until reg_ack, then 0.
- Halted; command=0x00221003, reg_rdata=0xCAFEF00D with reg_ack after 3 cycles -> data0 reads 0xCAFEF00D. Same command with no reg_ack -> after TIMEOUT cycles abstractcs[10:8]=3; writing 0x700 clears it.
- command=0x00231005 with hart_halted=0 -> cmderr=4, no reg_req.
- Request with op 3 -> resp 2.
- Assert dev_rst during A_WAIT -> all outputs 0 immediately.
